// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default payload widths, the stage control-field
// layout, the nop encoding used for bubbles, and a small occupancy helper.
package pipe_stage_reg_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 16;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [1:0] wb_sel;
    logic [5:0] alu_op;
    logic [3:0] wr_en;
  } stage_ctrl_t;

  // All-zero fields: no writes, ALU idle, no writeback.
  localparam stage_ctrl_t NOP_CTRL = '{rsvd: 4'h0, wb_sel: 2'b00, alu_op: 6'h00, wr_en: 4'h0};

  function automatic logic [1:0] held_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus payload register. Clear only drops the
// valid flag so the payload never toggles while the slot is empty.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Valid flag: clear beats load, and load beats unload so a same-edge refill keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

  // Payload register, loaded only on an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= {DATA_W{1'b0}};
      ctrl <= {CTRL_W{1'b0}};
    end else if (load && !clear) begin
      data <= in_data;
      ctrl <= in_ctrl;
    end else begin
      data <= data;
      ctrl <= ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush, and bubble control insertion when empty.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(NOP_CTRL),
  parameter int                SKID        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_load;
  logic              main_unload;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              skid_valid;
  logic              enq;
  logic              deq;

  assign enq = in_valid & in_ready & ~flush;
  assign deq = main_valid & out_ready & ~flush;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .load    (main_load),
    .unload  (main_unload),
    .in_data (main_src_data),
    .in_ctrl (main_src_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_load;
      logic              skid_unload;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .load    (skid_load),
        .unload  (skid_unload),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
      );

      assign in_ready = ~skid_valid;

      // Skid drains into main on dequeue; a new beat lands in skid only while main stays occupied.
      always_comb begin
        main_load     = (deq & skid_valid) | (enq & (~main_valid | deq));
        main_unload   = deq;
        skid_load     = enq & main_valid & (~deq | skid_valid);
        skid_unload   = deq & skid_valid;
        if (skid_valid) begin
          main_src_data = skid_data;
          main_src_ctrl = skid_ctrl;
        end else begin
          main_src_data = in_data;
          main_src_ctrl = in_ctrl;
        end
      end
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign in_ready   = ~main_valid | out_ready;

      always_comb begin
        main_load     = enq;
        main_unload   = deq;
        main_src_data = in_data;
        main_src_ctrl = in_ctrl;
      end
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign occupancy = held_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for the skid configuration
// plus hand-written sequences for hold, reset-over-flush and the single-entry mode.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam logic [CW-1:0] BUB = 8'hA5;

  logic clk;
  logic rst;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0] occupancy;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0] b_occupancy;

  int passed;
  int total;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          f;
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    occ;
    logic          ir;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    else passed = passed + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string nm, input logic ov, input logic [DW-1:0] od,
                          input logic [CW-1:0] oc, input logic [1:0] occ, input logic ir);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".out_data"}, 32'(out_data), 32'(od));
    chk({nm, ".out_ctrl"}, 32'(out_ctrl), 32'(oc));
    chk({nm, ".occupancy"}, 32'(occupancy), 32'(occ));
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(ir));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_ctrl = 8'h0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0; b_in_ctrl = 8'h0; b_out_ready = 1'b0;

    //           f     iv    d         c      ordy | ov    od        oc     occ   ir
    vecs[0]  = '{1'b0, 1'b1, 16'h0001, 8'h01, 1'b1, 1'b1, 16'h0001, 8'h01, 2'd1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 16'h0002, 8'h02, 1'b1, 1'b1, 16'h0002, 8'h02, 2'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 16'h0003, 8'h03, 1'b1, 1'b1, 16'h0003, 8'h03, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0003, BUB,   2'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'h000A, 8'h0A, 1'b0, 1'b1, 16'h000A, 8'h0A, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'h000B, 8'h0B, 1'b0, 1'b1, 16'h000A, 8'h0A, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h000C, 8'h0C, 1'b0, 1'b1, 16'h000A, 8'h0A, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h000D, 8'h0D, 1'b1, 1'b1, 16'h000B, 8'h0B, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h000B, BUB,   2'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0011, 8'h11, 1'b0, 1'b1, 16'h0011, 8'h11, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'h0022, 8'h22, 1'b0, 1'b1, 16'h0011, 8'h11, 2'd2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'h0033, 8'h33, 1'b1, 1'b0, 16'h0011, BUB,   2'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0011, BUB,   2'd0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 16'h0044, 8'h44, 1'b1, 1'b0, 16'h0011, BUB,   2'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 16'h0055, 8'h55, 1'b1, 1'b1, 16'h0055, 8'h55, 2'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0055, BUB,   2'd0, 1'b1};

    tick();
    tick();
    chk_main("reset", 1'b0, 16'h0000, BUB, 2'd0, 1'b1);
    chk("reset.b_out_valid", 32'(b_out_valid), 32'd0);
    chk("reset.b_out_ctrl", 32'(b_out_ctrl), 32'(BUB));
    chk("reset.b_occupancy", 32'(b_occupancy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      flush = vecs[i].f; in_valid = vecs[i].iv; in_data = vecs[i].d;
      in_ctrl = vecs[i].c; out_ready = vecs[i].ordy;
      tick();
      chk_main($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].oc, vecs[i].occ, vecs[i].ir);
    end
    flush = 1'b0;

    // Stalled head must not move while upstream data wiggles.
    in_valid = 1'b1; in_data = 16'h0077; in_ctrl = 8'h77; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'($urandom);
      in_ctrl = 8'($urandom);
      tick();
      chk_main($sformatf("hold%0d", i), 1'b1, 16'h0077, 8'h77, 2'd1, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("hold.drain_valid", 32'(out_valid), 32'd0);

    // Reset wins over flush and an offered beat on a full stage.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0061; in_ctrl = 8'h61;
    tick();
    in_data = 16'h0062; in_ctrl = 8'h62;
    tick();
    chk("full.occupancy", 32'(occupancy), 32'd2);
    rst = 1'b1; flush = 1'b1; in_data = 16'h0063; in_ctrl = 8'h63;
    tick();
    chk_main("rst_flush", 1'b0, 16'h0000, BUB, 2'd0, 1'b1);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    // Single-entry mode: ready passes straight through from downstream.
    b_in_valid = 1'b1; b_in_data = 16'h0099; b_in_ctrl = 8'h99; b_out_ready = 1'b0;
    tick();
    chk("s0.occ_full", 32'(b_occupancy), 32'd1);
    chk("s0.out_data", 32'(b_out_data), 32'h99);
    chk("s0.ready_lo", 32'(b_in_ready), 32'd0);
    b_in_data = 16'h009A; b_in_ctrl = 8'h9A;
    tick();
    chk("s0.occ_stall", 32'(b_occupancy), 32'd1);
    chk("s0.data_stall", 32'(b_out_data), 32'h99);
    b_out_ready = 1'b1;
    #1;
    chk("s0.ready_follow_hi", 32'(b_in_ready), 32'd1);
    b_out_ready = 1'b0;
    #1;
    chk("s0.ready_follow_lo", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("s0.occ_swap", 32'(b_occupancy), 32'd1);
    chk("s0.data_swap", 32'(b_out_data), 32'h9A);
    chk("s0.ctrl_swap", 32'(b_out_ctrl), 32'h9A);
    b_in_valid = 1'b0;
    tick();
    chk("s0.empty_valid", 32'(b_out_valid), 32'd0);
    chk("s0.empty_ctrl", 32'(b_out_ctrl), 32'(BUB));
    chk("s0.empty_occ", 32'(b_occupancy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the datapath payload (operands, immediates, link address).
REQ-002 SHALL have parameter CTRL_W, default 16: width of the control payload (write enables, ALU op, writeback select).
REQ-003 SHALL have parameter BUBBLE_CTRL, default 0: control value presented whenever no valid beat is held (nop encoding).
REQ-004 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer; 0 = single entry.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  input  1  discard all held beats plus the beat offered this cycle.
REQ-008 SHALL have port in_valid  input  1  upstream beat present.
REQ-009 SHALL have port in_ready  output  1  stage accepts a beat this cycle.
REQ-010 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-011 SHALL have port in_ctrl  input  CTRL_W  upstream control.
REQ-012 SHALL have port out_valid  output  1  downstream beat present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_data  output  DATA_W  head payload.
REQ-015 SHALL have port out_ctrl  output  CTRL_W  head control; BUBBLE_CTRL when out_valid=0.
REQ-016 SHALL have port occupancy  output  2  number of held beats (0..2; max 1 when SKID=0).

Function
REQ-017 SHALL transfer a beat on the input side iff in_valid & in_ready, and on the output side iff out_valid & out_ready.
REQ-018 SHALL have a latency of exactly 1 cycle from an accepted input beat to out_valid when the stage is empty.
REQ-019 SHALL, with SKID=1, drive in_ready from a register only: in_ready = !skid_valid.
REQ-020 SHALL, with SKID=1, place an accepted beat in the skid entry when the main entry is held and not dequeued that cycle; otherwise the beat goes to the main entry.
REQ-021 SHALL, on dequeue of the main entry while the skid entry is valid, move skid to main in the same edge; a simultaneous input beat then enters skid.
REQ-022 SHALL, with SKID=0, drive in_ready = !main_valid | out_ready (combinational pass-through of ready).
REQ-023 SHALL preserve beat order; no beat is duplicated or lost except by flush or rst.
REQ-024 SHALL, when flush=1, clear both entries at the edge, ignore in_valid that cycle and report out_valid=0 on the next cycle; flush overrides a simultaneous enqueue or dequeue.
REQ-025 SHALL keep out_data and out_ctrl stable while out_valid=1 and out_ready=0.
REQ-026 SHALL force out_ctrl=BUBBLE_CTRL combinationally whenever out_valid=0; out_data is then don't-care but SHALL hold its last value (no toggling).
REQ-027 SHALL update occupancy at every edge as held + enq - deq (0 after flush/rst).

Reset
REQ-028 SHALL, on rst, clear main_valid and skid_valid, giving out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0 and in_ready=1.
REQ-029 SHALL give rst priority over flush, and flush priority over normal transfer.

Structure
REQ-030 SHALL take the default widths and the BUBBLE_CTRL nop encoding from the shared pipeline package, alongside the stage control-field layout.
REQ-031 SHALL implement each entry as one sub-module, pipe_slot (valid + data + ctrl register with load/clear), instantiated once or twice depending on SKID.

Verification
REQ-032 SHALL verify that with SKID=1 and out_ready=1, streaming beats D=1,2,3 on consecutive cycles appear on out_data on the next consecutive cycles with in_ready constantly 1.
REQ-033 SHALL verify that when out_ready is held 0 and beats A, B are sent, occupancy=2 and in_ready=0 on the cycle after B; raising out_ready then yields A then B.
REQ-034 SHALL verify that a beat C offered with flush=1 while occupancy=2 is dropped, and the stage shows occupancy=0, out_valid=0 and out_ctrl=BUBBLE_CTRL on the next cycle.
REQ-035 SHALL verify that with out_ready=0 and out_valid=1, out_data/out_ctrl stay unchanged for 5 cycles despite in_data changes.
REQ-036 SHALL verify that with SKID=0 and main full, toggling out_ready toggles in_ready in the same cycle, and occupancy never exceeds 1.
REQ-037 SHALL verify that asserting rst together with flush and in_valid on a full stage gives every output its REQ-028 reset value on the next cycle.
